// File: rtl/alu_input_loader.sv
// ---------------------------------------------------------------------------
// alu_input_loader
//
// Operand/opcode front end for the 8-op ALU on the FPGA board.
//
// The slide switches are shared by all three values. They are loaded in a
// fixed order: A, then B, then the opcode. Each value has its own button.
// The loaded registers drive the ALU inputs directly. While the result is
// shown, the ALU outputs are captured into the LED register.
//
// Optional feature (compile-time macro): DEBOUNCE_EN
//   defined   : each synchronized button level must differ from its stable
//               level for DEBOUNCE_CYCLES consecutive cycles before the
//               stable level follows it; a press is a rising edge of the
//               stable level.
//   undefined : a press is a rising edge of the synchronized level;
//               DEBOUNCE_CYCLES is unused.
//
// Ports
//   i_clk             system clock, rising edge
//   i_reset           asynchronous, active-high reset
//   i_sw              slide switches (value to load)
//   i_btn_a/_b/_op    raw buttons: load A / B / opcode (asynchronous)
//   i_alu_result      ALU result
//   i_alu_overflow    ALU overflow flag
//   i_alu_zero        ALU zero flag
//   o_data_a/_b       operand registers, to the ALU
//   o_operation_code  opcode register, to the ALU
//   o_leds            {overflow, zero, result} captured while showing
//   o_state           current FSM state (0=A, 1=B, 2=OP, 3=SHOW)
//   o_op_error        one-cycle pulse when an illegal opcode is rejected
// ---------------------------------------------------------------------------
module alu_input_loader #(
    parameter int NB_DATA         = 8,
    parameter int NB_OP           = 6,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_sw,
    input  logic                 i_btn_a,
    input  logic                 i_btn_b,
    input  logic                 i_btn_op,
    input  logic [NB_DATA-1:0]   i_alu_result,
    input  logic                 i_alu_overflow,
    input  logic                 i_alu_zero,
    output logic [NB_DATA-1:0]   o_data_a,
    output logic [NB_DATA-1:0]   o_data_b,
    output logic [NB_OP-1:0]     o_operation_code,
    output logic [NB_DATA+1:0]   o_leds,
    output logic [1:0]           o_state,
    output logic                 o_op_error
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    // Button vector bit order: 0 = A, 1 = B, 2 = opcode.
    localparam int BTN_A  = 0;
    localparam int BTN_B  = 1;
    localparam int BTN_OP = 2;

    logic [2:0] btn_raw;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] prev_q;
    logic [2:0] lvl;
    logic [2:0] press;

    assign btn_raw = {i_btn_op, i_btn_b, i_btn_a};

    // Two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q [3];
    logic [2:0]       stab_q;

    // The counter counts consecutive cycles where the level disagrees with
    // the stable level. Any agreeing cycle restarts it, so glitches shorter
    // than DEBOUNCE_CYCLES never reach the stable level.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            stab_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == stab_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stab_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign lvl = stab_q;
`else
    assign lvl = sync2_q;
`endif

    // prev_q resets to 0, so a button held through reset release yields
    // exactly one rising edge afterwards.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= lvl;
        end
    end

    assign press = lvl & ~prev_q;

    function automatic logic op_legal(input logic [NB_OP-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            NB_OP'(6'b100000),
            NB_OP'(6'b100010),
            NB_OP'(6'b100100),
            NB_OP'(6'b100101),
            NB_OP'(6'b100110),
            NB_OP'(6'b000011),
            NB_OP'(6'b000010),
            NB_OP'(6'b100111): ok = 1'b1;
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t              state_q;
    logic [NB_DATA-1:0]  a_q;
    logic [NB_DATA-1:0]  b_q;
    logic [NB_OP-1:0]    op_q;
    logic [NB_DATA+1:0]  leds_q;
    logic                err_q;
    logic [NB_OP-1:0]    sw_op;

    assign sw_op = i_sw[NB_OP-1:0];

    // Only the press of the button owned by the current state is acted on.
    // Other presses are single-cycle pulses, so they are dropped, not queued.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            leds_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_A: begin
                    if (press[BTN_A]) begin
                        a_q     <= i_sw;
                        state_q <= S_B;
                    end
                end
                S_B: begin
                    if (press[BTN_B]) begin
                        b_q     <= i_sw;
                        state_q <= S_OP;
                    end
                end
                S_OP: begin
                    if (press[BTN_OP]) begin
                        if (op_legal(sw_op)) begin
                            op_q    <= sw_op;
                            state_q <= S_SHOW;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_SHOW: begin
                    // The ALU is combinational on a_q/b_q/op_q. The capture
                    // on the exit edge still sees the old operands, so the
                    // LEDs keep the last shown result.
                    leds_q <= {i_alu_overflow, i_alu_zero, i_alu_result};
                    if (press[BTN_A]) begin
                        a_q     <= i_sw;
                        state_q <= S_B;
                    end
                end
                default: state_q <= S_A;
            endcase
        end
    end

    assign o_data_a         = a_q;
    assign o_data_b         = b_q;
    assign o_operation_code = op_q;
    assign o_leds           = leds_q;
    assign o_state          = state_q;
    assign o_op_error       = err_q;

endmodule
